// File: rtl/bcd_pkg.sv
// Shared constants, state encoding and digit checks for the serial BCD subtractor.
package bcd_pkg;

  localparam int DIGIT_W  = 4;
  localparam int BCD_MAX  = 9;
  localparam int BCD_BASE = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    COMP = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic digit_ok(input logic [DIGIT_W-1:0] d);
    return d <= DIGIT_W'(BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_sub_bw.sv
// One BCD digit subtract with borrow: d = a_d - b_d - bw_in, wrapped into 0..9.
module bcd_digit_sub_bw
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] a_d,
  input  logic [DIGIT_W-1:0] b_d,
  input  logic               bw_in,
  output logic [DIGIT_W-1:0] d,
  output logic               bw_out
);

  logic signed [DIGIT_W:0] t;

  // A negative 5-bit result keeps t+16 in its low nibble, so adding 10 mod 16 yields t+10.
  always_comb begin
    t      = signed'({1'b0, a_d}) - signed'({1'b0, b_d}) - signed'({{DIGIT_W{1'b0}}, bw_in});
    bw_out = t[DIGIT_W];
    if (bw_out) begin
      d = t[DIGIT_W-1:0] + DIGIT_W'(BCD_BASE);
    end else begin
      d = t[DIGIT_W-1:0];
    end
  end

endmodule

// File: rtl/bcd_serial_sub.sv
// Serial packed-BCD subtractor producing |a - b| and sign, one digit per clock,
// with a second pass that 10's-complements a negative raw result.
module bcd_serial_sub
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   diff,
  output logic                  neg,
  output logic                  err
);

  localparam int W     = DIGIT_W * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_t           state, state_next;
  logic [W-1:0]     a_reg, b_reg, diff_reg;
  logic             neg_reg, err_reg;
  logic [IDX_W-1:0] idx;
  logic             bw;

  logic             bad_in;
  logic             last;
  logic [DIGIT_W-1:0] op_a, op_b, d;
  logic             bw_out;

  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!digit_ok(a[i*DIGIT_W +: DIGIT_W]) || !digit_ok(b[i*DIGIT_W +: DIGIT_W])) begin
        bad_in = 1'b1;
      end
    end
  end

  // COMP reuses the same digit stage to compute 0 - r_i - bw over the stored result.
  always_comb begin
    last = (idx == LAST_IDX);
    if (state == COMP) begin
      op_a = '0;
      op_b = diff_reg[idx*DIGIT_W +: DIGIT_W];
    end else begin
      op_a = a_reg[idx*DIGIT_W +: DIGIT_W];
      op_b = b_reg[idx*DIGIT_W +: DIGIT_W];
    end
  end

  bcd_digit_sub_bw u_digit (
    .a_d   (op_a),
    .b_d   (op_b),
    .bw_in (bw),
    .d     (d),
    .bw_out(bw_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = bad_in ? DONE : SUB;
      SUB:  if (last)     state_next = bw_out ? COMP : DONE;
      COMP: if (last)     state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default:            state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    diff      = diff_reg;
    neg       = neg_reg;
    err       = err_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      diff_reg <= '0;
      neg_reg  <= 1'b0;
      err_reg  <= 1'b0;
      idx      <= '0;
      bw       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= a;
            b_reg    <= b;
            diff_reg <= '0;
            neg_reg  <= 1'b0;
            err_reg  <= bad_in;
            idx      <= '0;
            bw       <= 1'b0;
          end
        end
        SUB, COMP: begin
          diff_reg[idx*DIGIT_W +: DIGIT_W] <= d;
          if (last) begin
            idx <= '0;
            bw  <= 1'b0;
            // A borrow out of the top digit is the only way the result goes negative.
            if (state == SUB) neg_reg <= bw_out;
          end else begin
            idx <= idx + 1'b1;
            bw  <= bw_out;
          end
        end
        DONE: begin
          if (out_ready) err_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_sub.sv
// Directed bench for bcd_serial_sub: vector table plus backpressure and mid-run reset sequences.
module tb_bcd_serial_sub;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         neg;
  logic         err;

  int tests = 0;
  int fails = 0;

  bcd_serial_sub #(.DIGITS(DIGITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .neg      (neg),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         neg;
    logic         err;
    int           lat;
  } vec_t;

  vec_t vecs[12];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // lat = number of clock edges after the accept edge until out_valid is seen high.
  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv, output int lat);
    @(negedge clk);
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = 16'hFFFF;
    b        = 16'hAAAA;
    lat      = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic releaseResult(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput({name, " in_ready after release"}, 32'(in_ready), 32'd1);
    checkOutput({name, " out_valid after release"}, 32'(out_valid), 32'd0);
    checkOutput({name, " err after release"}, 32'(err), 32'd0);
  endtask

  initial begin
    int lat;
    logic [W-1:0] held_diff;

    vecs[0]  = '{16'h5321, 16'h1234, 16'h4087, 1'b0, 1'b0, 4};
    vecs[1]  = '{16'h1234, 16'h5321, 16'h4087, 1'b1, 1'b0, 8};
    vecs[2]  = '{16'h0000, 16'h0001, 16'h0001, 1'b1, 1'b0, 8};
    vecs[3]  = '{16'h9999, 16'h9999, 16'h0000, 1'b0, 1'b0, 4};
    vecs[4]  = '{16'h12A4, 16'h0001, 16'h0000, 1'b0, 1'b1, 0};
    vecs[5]  = '{16'h0000, 16'h9999, 16'h9999, 1'b1, 1'b0, 8};
    vecs[6]  = '{16'h1000, 16'h0001, 16'h0999, 1'b0, 1'b0, 4};
    vecs[7]  = '{16'h0500, 16'h0499, 16'h0001, 1'b0, 1'b0, 4};
    vecs[8]  = '{16'h0001, 16'h1000, 16'h0999, 1'b1, 1'b0, 8};
    vecs[9]  = '{16'h9999, 16'h0000, 16'h9999, 1'b0, 1'b0, 4};
    vecs[10] = '{16'h0000, 16'hF000, 16'h0000, 1'b0, 1'b1, 0};
    vecs[11] = '{16'h4321, 16'h0876, 16'h3445, 1'b0, 1'b0, 4};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset diff", 32'(diff), 32'd0);
    checkOutput("reset neg", 32'(neg), 32'd0);
    checkOutput("reset err", 32'(err), 32'd0);

    for (int i = 0; i < 12; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      applyStimulus(vecs[i].a, vecs[i].b, lat);
      checkOutput({nm, " latency"}, 32'(lat), 32'(vecs[i].lat));
      checkOutput({nm, " out_valid"}, 32'(out_valid), 32'd1);
      checkOutput({nm, " in_ready"}, 32'(in_ready), 32'd0);
      checkOutput({nm, " diff"}, 32'(diff), 32'(vecs[i].diff));
      checkOutput({nm, " neg"}, 32'(neg), 32'(vecs[i].neg));
      checkOutput({nm, " err"}, 32'(err), 32'(vecs[i].err));
      releaseResult(nm);
    end

    // Backpressure: hold DONE for 5 cycles while poking in_valid with other operands.
    applyStimulus(16'h1234, 16'h5321, lat);
    checkOutput("bp latency", 32'(lat), 32'd8);
    held_diff = 16'h4087;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = c[0];
      a        = 16'h0002;
      b        = 16'h0001;
      @(posedge clk);
      #1;
      checkOutput($sformatf("bp c%0d out_valid", c), 32'(out_valid), 32'd1);
      checkOutput($sformatf("bp c%0d in_ready", c), 32'(in_ready), 32'd0);
      checkOutput($sformatf("bp c%0d diff", c), 32'(diff), 32'(held_diff));
      checkOutput($sformatf("bp c%0d neg", c), 32'(neg), 32'd1);
    end
    in_valid = 1'b0;
    releaseResult("bp");

    // Reset lands on the second SUB edge; digit 0 (7) has already been written by then.
    @(negedge clk);
    a        = 16'h5321;
    b        = 16'h1234;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst mid diff digit0", 32'(diff), 32'h0007);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst mid in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst mid out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst mid diff", 32'(diff), 32'd0);
    checkOutput("rst mid neg", 32'(neg), 32'd0);

    applyStimulus(16'h0250, 16'h0731, lat);
    checkOutput("post rst latency", 32'(lat), 32'd8);
    checkOutput("post rst diff", 32'(diff), 32'h0481);
    checkOutput("post rst neg", 32'(neg), 32'd1);
    checkOutput("post rst err", 32'(err), 32'd0);
    releaseResult("post rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bcd_serial_sub.md
# bcd_serial_sub

Multi-digit packed-BCD subtractor that computes |A − B| and its sign, one digit per clock with a borrow chain. It feeds the per-digit BCD subtract stage and converts its raw 10's-complement result into sign-magnitude form. It sits between operand capture (valid/ready source) and the BCD display/formatting logic (valid/ready sink).

## Interface
- DIGITS, 4: number of BCD digits per operand; ≥ 1
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands; high only in IDLE
- a  input  4*DIGITS  minuend, packed BCD, digit 0 = bits [3:0] (LSD)
- b  input  4*DIGITS  subtrahend, same packing
- out_valid  output  1  result valid; high only in DONE
- out_ready  input  1  sink accepts result
- diff  output  4*DIGITS  |a − b| in packed BCD
- neg  output  1  1 when a < b
- err  output  1  1 when any input digit of a or b is > 9

## Operation
- States: IDLE, SUB, COMP, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, capture a, b; clear digit index and borrow.
  - If any digit of a or b > 9: go to DONE, err=1, diff=0, neg=0.
  - Else go to SUB.
- SUB: per cycle, digit i: t = a_i − b_i − bw. If t < 0: d_i = t + 10, bw=1; else d_i = t, bw=0. Write d_i into diff[4i+3:4i]; i++.
  - After digit DIGITS−1: final bw=0 → DONE, neg=0; final bw=1 → COMP, neg=1, i=0, bw=0.
- COMP: 10's-complement the stored result: d_i = 0 − r_i − bw with the same rule; same one-digit-per-cycle walk; after last digit → DONE.
- DONE: out_valid=1; diff/neg/err held stable. On out_ready → IDLE, err cleared.
- Equal operands: diff=0, neg=0 (never "negative zero").
- All digit arithmetic in 5-bit signed; stored digits always 0..9.
- Input data ignored outside IDLE; no overlap of operations.

## Timing
- Reset: state=IDLE, in_ready=1, out_valid=0, diff=0, neg=0, err=0, index=0, borrow=0.
- Accept edge T. Non-negative result: out_valid high after edge T+DIGITS. Negative: after edge T+2*DIGITS. Error: after edge T+1? No — error moves to DONE on edge T, out_valid high the cycle after T.
- out_valid&&out_ready at edge U → IDLE; in_ready high after U; next accept earliest at U+1.
- out_ready held low: DONE held indefinitely, outputs unchanged.
- rst in any state (including mid-SUB/COMP): abort at that edge, all outputs to reset values; in-flight result discarded.
- out_ready ignored outside DONE; in_valid ignored outside IDLE.

## Structure
- Package bcd_pkg: DIGIT_W=4, BCD_MAX=9, BCD_BASE=10, state enum (IDLE, SUB, COMP, DONE), digit-valid check function.
- Sub-module bcd_digit_sub_bw: combinational one-digit subtract with borrow-in/borrow-out (a_d, b_d, bw_in → d, bw_out); instanced once, reused by SUB (a_i, b_i) and COMP (0, r_i) via input mux.
- Top: FSM, digit index counter (clog2(DIGITS) bits), borrow flop, operand and result shift/index registers.

## Test plan
- a=0x5321, b=0x1234 → diff=0x4087, neg=0, err=0; out_valid 4 cycles after accept.
- a=0x1234, b=0x5321 → diff=0x4087, neg=1; out_valid 8 cycles after accept.
- a=0x0000, b=0x0001 → diff=0x0001, neg=1; a=b=0x9999 → diff=0x0000, neg=0.
- a=0x12A4, b=0x0001 → err=1, diff=0, neg=0; out_valid 1 cycle after accept.
- Backpressure: out_ready low 5 cycles in DONE → out_valid, diff, neg constant; in_ready stays 0; in_valid pulses ignored.
- rst asserted in cycle 2 of SUB → next cycle in_ready=1, out_valid=0, diff=0; new operation afterwards yields correct result.
